// File: rtl/serial_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_sender : byte FIFO feeding an 8N1 transmitter with per-frame baud.
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_sender #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_D,
  input  logic                     i_write,
  input  logic [15:0]              i_baud,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic                     o_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, ovf_q, tx_q;
  logic [7:0]    shift_q;
  logic [15:0]   period_q, cnt_q, baud_eff;
  logic [2:0]    bit_q;
  logic          wr_acc, pop, bit_end;

  // A write is judged against the registered full flag, so a same-cycle pop cannot rescue it.
  assign wr_acc   = i_write & ~full_q;
  assign bit_end  = (cnt_q == 16'd0);
  assign pop      = (level_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign baud_eff = (i_baud == 16'd0) ? 16'd1 : i_baud;

  always_comb begin
    level_d = level_q;
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_D;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      ovf_q   <= i_write & full_q;
    end
  end

  // The line register follows the state of the previous cycle, keeping every
  // bit exactly one period long while staying glitch-free.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      shift_q  <= 8'd0;
      period_q <= 16'd0;
      cnt_q    <= 16'd0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            period_q <= baud_eff;
            cnt_q    <= baud_eff - 16'd1;
            bit_q    <= 3'd0;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= period_q - 16'd1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q   <= period_q - 16'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
              period_q <= baud_eff;
              cnt_q    <= baud_eff - 16'd1;
              bit_q    <= 3'd0;
              state_q  <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign o_full     = full_q;
  assign o_level    = level_q;
  assign o_busy     = (state_q != IDLE);
  assign o_overflow = ovf_q;
  assign o_tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_sender : randomized and directed bench against a frame-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_sender;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          i_clk   = 1'b0;
  logic          i_rst   = 1'b1;
  logic          i_write = 1'b0;
  logic [7:0]    i_D     = 8'd0;
  logic [15:0]   i_baud  = 16'd0;
  logic          o_full, o_busy, o_overflow, o_tx;
  logic [LW-1:0] o_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: a byte queue plus "cycles left in the current frame".
  logic [7:0] m_q[$];
  int         m_remain = 0;
  int         m_p      = 1;
  logic [9:0] m_frame  = 10'h3FF;
  logic       m_tx     = 1'b1;
  logic       m_ovf    = 1'b0;

  logic [LW+3:0] dut_vec;
  assign dut_vec = {o_tx, o_busy, o_full, o_overflow, o_level};

  serial_sender #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_D(i_D), .i_write(i_write), .i_baud(i_baud),
    .o_full(o_full), .o_level(o_level), .o_busy(o_busy), .o_overflow(o_overflow), .o_tx(o_tx)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [LW+3:0] exp_vec();
    return {m_tx, (m_remain > 0), (m_q.size() == DEPTH), m_ovf, LW'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_remain = 0;
    m_tx     = 1'b1;
    m_ovf    = 1'b0;
  endtask

  // Advance model and DUT across one rising edge; returns 1 µs-free, #1 after the edge.
  task automatic tick();
    int el;
    logic do_pop;
    if (m_remain > 0) begin
      el   = 10 * m_p - m_remain;
      m_tx = m_frame[el / m_p];
    end else begin
      m_tx = 1'b1;
    end
    m_ovf  = i_write && (m_q.size() == DEPTH);
    do_pop = (m_q.size() != 0) && (m_remain <= 1);
    if (m_remain > 0) m_remain--;
    if (do_pop) begin
      m_frame  = {1'b1, m_q.pop_front(), 1'b0};
      m_p      = (i_baud == 16'd0) ? 1 : int'(i_baud);
      m_remain = 10 * m_p;
    end
    if (i_write && !m_ovf) m_q.push_back(i_D);
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    #3;
    i_rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, 1'b0, {LW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec, {1'b1, 3'b000, {LW{1'b0}}});
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_a5_baud4();
    int busy_n = 0;
    i_baud = 16'd4; i_D = 8'hA5; i_write = 1'b1;
    tick();
    i_write = 1'b0;
    repeat (48) begin
      tick();
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL a5_frame cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (busy_n != 40) begin
      failures++;
      $display("FAIL a5_busy_len got=%0d exp=40", busy_n);
    end
  endtask

  task automatic test_baud0();
    int busy_n = 0;
    i_baud = 16'd0; i_D = 8'h00; i_write = 1'b1;
    tick();
    i_write = 1'b0;
    repeat (14) begin
      tick();
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL baud0_frame cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (busy_n != 10) begin
      failures++;
      $display("FAIL baud0_busy_len got=%0d exp=10", busy_n);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    int ovf_n  = 0;
    int full_n = 0;
    i_baud = 16'd2;
    repeat (DEPTH + 2) begin
      i_D = 8'($urandom); i_write = 1'b1;
      tick();
      if (o_overflow === 1'b1) ovf_n++;
      if (o_full === 1'b1) full_n++;
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_fill cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    i_write = 1'b0;
    repeat (120) begin
      tick();
      if (o_overflow === 1'b1) ovf_n++;
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_drain cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (ovf_n != 1 || full_n == 0) begin
      failures++;
      $display("FAIL b2b_overflow got=%0d full_seen=%0d exp=1", ovf_n, full_n);
    end
    checks++;
    if (busy_n != 20 * (DEPTH + 1)) begin
      failures++;
      $display("FAIL b2b_contiguous busy=%0d exp=%0d", busy_n, 20 * (DEPTH + 1));
    end
  endtask

  task automatic test_baud_change();
    int busy_n = 0;
    i_baud = 16'd3; i_D = 8'h55; i_write = 1'b1;
    tick();
    i_write = 1'b0;
    repeat (8) begin
      tick();
      if (o_busy === 1'b1) busy_n++;
    end
    i_baud = 16'd8; i_D = 8'h0F; i_write = 1'b1;
    tick();
    if (o_busy === 1'b1) busy_n++;
    i_write = 1'b0;
    repeat (110) begin
      tick();
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL baud_change cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (busy_n != 110) begin
      failures++;
      $display("FAIL baud_change_len got=%0d exp=110", busy_n);
    end
  endtask

  task automatic test_reset_midframe();
    i_baud = 16'd10;
    i_D = 8'h3C; i_write = 1'b1;
    tick();
    i_D = 8'hC3;
    tick();
    i_write = 1'b0;
    repeat (25) tick();
    #2;
    i_rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, 1'b0, {LW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_midframe got=%b exp=%b", dut_vec, {1'b1, 3'b000, {LW{1'b0}}});
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (60) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    i_baud = 16'd1;
    repeat (DEPTH + 1) begin
      i_D = 8'($urandom); i_write = 1'b1;
      tick();
    end
    i_write = 1'b0;
    while (!(m_remain == 1 && m_q.size() == DEPTH) && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      failures++;
      $display("FAIL full_pop_setup timeout level=%0d exp=%0d", o_level, DEPTH);
    end
    i_D = 8'hEE; i_write = 1'b1;
    tick();
    i_write = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || o_level !== LW'(DEPTH - 1) || o_full !== 1'b0) begin
      failures++;
      $display("FAIL full_pop ovf=%b level=%0d full=%b exp ovf=1 level=%0d full=0",
               o_overflow, o_level, o_full, DEPTH - 1);
    end
    repeat (60) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL full_pop_drain cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      i_write = ($urandom_range(0, 2) == 0);
      i_D     = 8'($urandom);
      i_baud  = 16'($urandom_range(0, 3));
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    i_write = 1'b0;
    repeat (200) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5_baud4();
    test_baud0();
    test_back_to_back();
    test_baud_change();
    test_reset_midframe();
    test_full_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
